// File: rtl/memory_access_stage_pkg.sv
// Shared types and constants for the MEM stage and its byte-lane aligner.
package memory_access_stage_pkg;

  localparam int unsigned BE_W = 32'd4;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_RESP = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/memory_access_stage_lsu_align.sv
// Combinational byte-lane aligner: store enables/data, load extraction and
// extension, and the alignment/size legality check.
module lsu_align
  import memory_access_stage_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic [31:0]     rs2,
  input  logic [31:0]     rdata,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata,
  output logic [31:0]     load_ext,
  output logic            misaligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte/half out of the read word.
  always_comb begin
    byte_s = rdata[{addr_lo, 3'b000} +: 8];
    half_s = rdata[{addr_lo[1], 4'b0000} +: 16];
  end

  // Decode size/sign into lane enables, replicated store data and extended load data.
  always_comb begin
    be         = 4'b0000;
    wdata      = 32'd0;
    load_ext   = 32'd0;
    misaligned = 1'b1;
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << addr_lo;
        wdata      = {4{rs2[7:0]}};
        load_ext   = {{24{byte_s[7]}}, byte_s};
        misaligned = 1'b0;
      end
      F3_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata      = {4{rs2[7:0]}};
        load_ext   = {24'd0, byte_s};
        misaligned = 1'b0;
      end
      F3_H: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{rs2[15:0]}};
        load_ext   = {{16{half_s[15]}}, half_s};
        misaligned = addr_lo[0];
      end
      F3_HU: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{rs2[15:0]}};
        load_ext   = {16'd0, half_s};
        misaligned = addr_lo[0];
      end
      F3_W: begin
        be         = 4'b1111;
        wdata      = rs2;
        load_ext   = rdata;
        misaligned = |addr_lo;
      end
      default: begin
        be         = 4'b0000;
        wdata      = 32'd0;
        load_ext   = 32'd0;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: drives the req/gnt/rvalid data port, stalls upstream while an
// access is outstanding and registers the MEM/WB payload.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_valid_i,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic [2:0]            MEM_funct3_i,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_rs2_data_i,
  input  wb_sel_e               MEM_WBSel_i,
  input  logic                  MEM_RegWrite_i,
  input  logic [REG_ADDR_W-1:0] MEM_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] MEM_pc_plus4_i,
  output logic                  MEM_stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [BE_W-1:0]       dmem_be_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  WB_valid_o,
  output logic                  WB_RegWrite_o,
  output logic [REG_ADDR_W-1:0] WB_rd_addr_o,
  output wb_sel_e               WB_WBSel_o,
  output logic [DATA_WIDTH-1:0] WB_alu_result_o,
  output logic [DATA_WIDTH-1:0] WB_rd_data_o,
  output logic [DATA_WIDTH-1:0] WB_pc_plus4_o,
  output logic                  WB_misaligned_o
);

  mem_state_e            state_r;
  mem_state_e            state_next_s;
  logic                  is_load_s;
  logic                  is_store_s;
  logic                  mem_op_s;
  logic                  access_s;
  logic                  misaligned_op_s;
  logic                  req_s;
  logic                  complete_s;
  logic                  stall_s;
  logic [BE_W-1:0]       be_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [DATA_WIDTH-1:0] load_ext_s;
  logic                  misaligned_s;

  lsu_align u_lsu_align (
    .addr_lo    (MEM_alu_result_i[1:0]),
    .funct3     (MEM_funct3_i),
    .rs2        (MEM_rs2_data_i),
    .rdata      (dmem_rdata_i),
    .be         (be_s),
    .wdata      (wdata_s),
    .load_ext   (load_ext_s),
    .misaligned (misaligned_s)
  );

  // Classify the instruction in MEM; illegal size or alignment suppresses the access.
  always_comb begin
    is_load_s       = MEM_valid_i & MEM_MemRead_i;
    is_store_s      = MEM_valid_i & MEM_MemWrite_i;
    mem_op_s        = is_load_s | is_store_s;
    misaligned_op_s = mem_op_s & misaligned_s;
    access_s        = mem_op_s & ~misaligned_s;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= MS_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: a load goes to RESP after its grant, a store is done at its grant.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      MS_IDLE: begin
        if (access_s) begin
          if (dmem_gnt_i) begin
            state_next_s = is_load_s ? MS_RESP : MS_IDLE;
          end else begin
            state_next_s = MS_REQ;
          end
        end else begin
          state_next_s = MS_IDLE;
        end
      end
      MS_REQ: begin
        if (dmem_gnt_i) begin
          state_next_s = is_load_s ? MS_RESP : MS_IDLE;
        end else begin
          state_next_s = MS_REQ;
        end
      end
      MS_RESP: begin
        if (dmem_rvalid_i) begin
          state_next_s = MS_IDLE;
        end else begin
          state_next_s = MS_RESP;
        end
      end
      default: begin
        state_next_s = MS_IDLE;
      end
    endcase
  end

  // FSM outputs: request, completion and stall; reset forces the port quiet at once.
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      MS_IDLE: req_s = access_s;
      MS_REQ:  req_s = 1'b1;
      MS_RESP: req_s = 1'b0;
      default: req_s = 1'b0;
    endcase
    if ((is_store_s & req_s & dmem_gnt_i) ||
        (is_load_s & (state_r == MS_RESP) & dmem_rvalid_i)) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
    stall_s      = access_s & ~complete_s & ~rst;
    MEM_stall_o  = stall_s;
    dmem_req_o   = req_s & ~rst;
    dmem_we_o    = req_s & ~rst & MEM_MemWrite_i;
    dmem_addr_o  = {MEM_alu_result_i[DATA_WIDTH-1:2], 2'b00};
    if (req_s & ~rst) begin
      dmem_be_o    = be_s;
      dmem_wdata_o = wdata_s;
    end else begin
      dmem_be_o    = 4'b0000;
      dmem_wdata_o = 32'd0;
    end
  end

  // MEM/WB register: capture on completion or non-memory op, bubble otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_valid_o      <= 1'b0;
      WB_RegWrite_o   <= 1'b0;
      WB_rd_addr_o    <= '0;
      WB_WBSel_o      <= WB_SEL_ALU;
      WB_alu_result_o <= '0;
      WB_rd_data_o    <= '0;
      WB_pc_plus4_o   <= '0;
      WB_misaligned_o <= 1'b0;
    end else if (!MEM_valid_i) begin
      WB_valid_o      <= 1'b0;
      WB_RegWrite_o   <= 1'b0;
      WB_misaligned_o <= 1'b0;
    end else if (misaligned_op_s) begin
      WB_valid_o      <= 1'b1;
      WB_RegWrite_o   <= 1'b0;
      WB_rd_addr_o    <= MEM_rd_addr_i;
      WB_WBSel_o      <= MEM_WBSel_i;
      WB_alu_result_o <= MEM_alu_result_i;
      WB_rd_data_o    <= '0;
      WB_pc_plus4_o   <= MEM_pc_plus4_i;
      WB_misaligned_o <= 1'b1;
    end else if (stall_s) begin
      WB_valid_o      <= 1'b0;
      WB_RegWrite_o   <= 1'b0;
      WB_misaligned_o <= 1'b0;
    end else begin
      WB_valid_o      <= 1'b1;
      WB_RegWrite_o   <= MEM_RegWrite_i;
      WB_rd_addr_o    <= MEM_rd_addr_i;
      WB_WBSel_o      <= MEM_WBSel_i;
      WB_alu_result_o <= MEM_alu_result_i;
      WB_rd_data_o    <= is_load_s ? load_ext_s : '0;
      WB_pc_plus4_o   <= MEM_pc_plus4_i;
      WB_misaligned_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized self-checking bench for memory_access_stage with a behavioural
// model of lane selection, extension, alignment and handshake timing.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_valid_i, MEM_MemRead_i, MEM_MemWrite_i, MEM_RegWrite_i;
  logic [2:0]  MEM_funct3_i;
  logic [31:0] MEM_alu_result_i, MEM_rs2_data_i, MEM_pc_plus4_i;
  wb_sel_e     MEM_WBSel_i;
  logic [4:0]  MEM_rd_addr_i;
  logic        MEM_stall_o, dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        WB_valid_o, WB_RegWrite_o, WB_misaligned_o;
  logic [4:0]  WB_rd_addr_o;
  wb_sel_e     WB_WBSel_o;
  logic [31:0] WB_alu_result_o, WB_rd_data_o, WB_pc_plus4_o;

  int total = 0;
  int bad   = 0;

  memory_access_stage dut (
    .clk(clk), .rst(rst),
    .MEM_valid_i(MEM_valid_i), .MEM_MemRead_i(MEM_MemRead_i), .MEM_MemWrite_i(MEM_MemWrite_i),
    .MEM_funct3_i(MEM_funct3_i), .MEM_alu_result_i(MEM_alu_result_i), .MEM_rs2_data_i(MEM_rs2_data_i),
    .MEM_WBSel_i(MEM_WBSel_i), .MEM_RegWrite_i(MEM_RegWrite_i), .MEM_rd_addr_i(MEM_rd_addr_i),
    .MEM_pc_plus4_i(MEM_pc_plus4_i), .MEM_stall_o(MEM_stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .WB_valid_o(WB_valid_o), .WB_RegWrite_o(WB_RegWrite_o), .WB_rd_addr_o(WB_rd_addr_o),
    .WB_WBSel_o(WB_WBSel_o), .WB_alu_result_o(WB_alu_result_o), .WB_rd_data_o(WB_rd_data_o),
    .WB_pc_plus4_o(WB_pc_plus4_o), .WB_misaligned_o(WB_misaligned_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned f3_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz;
    sz = f3_size(f3);
    return (sz == 0) || ((addr % sz) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned v;
    v = ((1 << f3_size(f3)) - 1) << (addr % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    int unsigned sz;
    sz = f3_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
    int unsigned sz;
    logic [31:0] v;
    sz = f3_size(f3);
    v  = rdata >> (8 * (addr % 4));
    if (sz == 4) return v;
    v = v & ((32'd1 << (8 * sz)) - 32'd1);
    if (f3[2] == 1'b0 && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check_eq({tag, ".wb_valid"}, WB_valid_o, 1'b0);
    check_eq({tag, ".wb_regwrite"}, WB_RegWrite_o, 1'b0);
  endtask

  task automatic check_payload(input string tag, input bit exp_rw, input bit exp_mis);
    check_eq({tag, ".wb_valid"}, WB_valid_o, 1'b1);
    check_eq({tag, ".wb_regwrite"}, WB_RegWrite_o, exp_rw);
    check_eq({tag, ".wb_misaligned"}, WB_misaligned_o, exp_mis);
    check_eq({tag, ".wb_alu"}, WB_alu_result_o, MEM_alu_result_i);
    check_eq({tag, ".wb_rd_addr"}, WB_rd_addr_o, MEM_rd_addr_i);
    check_eq({tag, ".wb_pc4"}, WB_pc_plus4_o, MEM_pc_plus4_i);
    check_eq({tag, ".wb_sel"}, {30'd0, WB_WBSel_o}, {30'd0, MEM_WBSel_i});
  endtask

  // kind: 0 = non-memory, 1 = load, 2 = store. Entered and left just after a posedge.
  task automatic run_txn(input string tag, input bit valid, input int kind, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                         input int gdly, input int rdly);
    bit mis;
    bit rw;
    MEM_valid_i      = valid;
    MEM_MemRead_i    = (kind == 1);
    MEM_MemWrite_i   = (kind == 2);
    MEM_funct3_i     = f3;
    MEM_alu_result_i = addr;
    MEM_rs2_data_i   = rs2;
    MEM_rd_addr_i    = 5'($urandom_range(1, 31));
    MEM_pc_plus4_i   = $urandom;
    MEM_WBSel_i      = wb_sel_e'($urandom_range(0, 2));
    rw               = (kind == 1) ? 1'b1 : ((kind == 2) ? 1'b0 : 1'($urandom_range(0, 1)));
    MEM_RegWrite_i   = rw;
    dmem_gnt_i       = 1'b0;
    dmem_rvalid_i    = 1'b0;
    mis              = (kind != 0) && model_misaligned(f3, addr);
    if (!valid || kind == 0 || mis) begin
      #1;
      check_eq({tag, ".req"}, dmem_req_o, 1'b0);
      check_eq({tag, ".stall"}, MEM_stall_o, 1'b0);
      edge_sample();
      if (!valid) check_bubble(tag);
      else check_payload(tag, mis ? 1'b0 : rw, mis);
    end else begin
      for (int c = 0; c <= gdly; c++) begin
        dmem_gnt_i    = (c == gdly);
        dmem_rvalid_i = (kind == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        dmem_rdata_i  = $urandom;
        #1;
        check_eq({tag, ".req"}, dmem_req_o, 1'b1);
        check_eq({tag, ".we"}, dmem_we_o, (kind == 2));
        check_eq({tag, ".addr"}, dmem_addr_o, addr & 32'hFFFF_FFFC);
        check_eq({tag, ".be"}, dmem_be_o, model_be(f3, addr));
        if (kind == 2) check_eq({tag, ".wdata"}, dmem_wdata_o, model_wdata(f3, rs2));
        check_eq({tag, ".stall"}, MEM_stall_o, !(kind == 2 && c == gdly));
        edge_sample();
        if (kind == 2 && c == gdly) check_payload(tag, rw, 1'b0);
        else check_bubble(tag);
      end
      dmem_gnt_i = 1'b0;
      if (kind == 1) begin
        for (int c = 1; c <= rdly; c++) begin
          dmem_rvalid_i = (c == rdly);
          dmem_rdata_i  = (c == rdly) ? rdata : $urandom;
          #1;
          check_eq({tag, ".resp_req"}, dmem_req_o, 1'b0);
          check_eq({tag, ".resp_stall"}, MEM_stall_o, (c != rdly));
          edge_sample();
          if (c == rdly) begin
            check_payload(tag, rw, 1'b0);
            check_eq({tag, ".rd_data"}, WB_rd_data_o, model_load(f3, addr, rdata));
          end else begin
            check_bubble(tag);
          end
        end
      end
    end
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    MEM_valid_i = 1'b0; MEM_MemRead_i = 1'b0; MEM_MemWrite_i = 1'b0; MEM_RegWrite_i = 1'b0;
    MEM_funct3_i = 3'b000; MEM_alu_result_i = 32'd0; MEM_rs2_data_i = 32'd0;
    MEM_pc_plus4_i = 32'd0; MEM_WBSel_i = WB_SEL_ALU; MEM_rd_addr_i = 5'd0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    edge_sample();
    edge_sample();
    check_eq("reset.wb_valid", WB_valid_o, 1'b0);
    check_eq("reset.wb_regwrite", WB_RegWrite_o, 1'b0);
    check_eq("reset.wb_rd_data", WB_rd_data_o, 32'd0);
    check_eq("reset.wb_alu", WB_alu_result_o, 32'd0);
    check_eq("reset.wb_sel", {30'd0, WB_WBSel_o}, 32'd0);
    check_eq("reset.req", dmem_req_o, 1'b0);
    check_eq("reset.stall", MEM_stall_o, 1'b0);
    rst = 1'b0;

    // directed cases
    run_txn("lw_100",  1'b1, 1, F3_W,  32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 1);
    run_txn("lb_103",  1'b1, 1, F3_B,  32'h0000_0103, 32'd0, 32'h80FF_FFFF, 0, 1);
    run_txn("lbu_103", 1'b1, 1, F3_BU, 32'h0000_0103, 32'd0, 32'h80FF_FFFF, 1, 2);
    run_txn("sh_102",  1'b1, 2, F3_H,  32'h0000_0102, 32'h1234_ABCD, 32'd0, 3, 1);
    run_txn("lw_101",  1'b1, 1, F3_W,  32'h0000_0101, 32'd0, 32'd0, 0, 1);
    run_txn("add_55",  1'b1, 0, 3'b000, 32'h0000_0055, 32'd0, 32'd0, 0, 1);
    run_txn("ld_f3_3", 1'b1, 1, 3'b011, 32'h0000_0200, 32'd0, 32'd0, 0, 1);
    run_txn("idle",    1'b0, 1, F3_W,  32'h0000_0100, 32'd0, 32'd0, 0, 1);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn("rand", ($urandom_range(0, 9) != 0), int'($urandom_range(0, 2)),
              3'($urandom_range(0, 7)), a, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end

    // reset while a load waits in RESP; the late rvalid must be dropped
    MEM_valid_i = 1'b1; MEM_MemRead_i = 1'b1; MEM_MemWrite_i = 1'b0; MEM_funct3_i = F3_W;
    MEM_alu_result_i = 32'h0000_0100; MEM_RegWrite_i = 1'b1;
    dmem_gnt_i = 1'b1;
    #1;
    check_eq("rst_mid.req", dmem_req_o, 1'b1);
    edge_sample();
    dmem_gnt_i = 1'b0;
    #1;
    check_eq("rst_mid.resp_stall", MEM_stall_o, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid.req_drop", dmem_req_o, 1'b0);
    check_eq("rst_mid.stall_drop", MEM_stall_o, 1'b0);
    check_eq("rst_mid.wb_valid", WB_valid_o, 1'b0);
    check_eq("rst_mid.wb_rd_data", WB_rd_data_o, 32'd0);
    MEM_valid_i = 1'b0; MEM_MemRead_i = 1'b0;
    edge_sample();
    rst = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hDEAD_BEEF;
    #1;
    check_eq("late_rvalid.req", dmem_req_o, 1'b0);
    edge_sample();
    dmem_rvalid_i = 1'b0;
    check_eq("late_rvalid.wb_valid", WB_valid_o, 1'b0);
    check_eq("late_rvalid.wb_rd_data", WB_rd_data_o, 32'd0);
    run_txn("post_rst_lw", 1'b1, 1, F3_W, 32'h0000_0040, 32'd0, 32'h0BAD_F00D, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
